// File: rtl/seq_pattern_gen_if.sv
// Control and serial-stream bundle between a pattern-source controller
// (master) and the serial pattern generator (slave).
interface seq_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] rep_num;
  logic             hold;
  logic             abort;
  logic             d_out;
  logic             d_valid;
  logic             eop;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, rep_num, hold, abort,
    input  d_out, d_valid, eop, busy, done
  );

  modport slave (
    input  start, pattern, rep_num, hold, abort,
    output d_out, d_valid, eop, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out
// MSB-first, repeated rep_num times with GAP_LEN fill bits between
// repetitions. EOP marks the LSB of every repetition so a downstream
// sequence detector's match can be checked cycle-for-cycle.
module seq_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int REP_W    = 4,
  parameter int GAP_LEN  = 2,
  parameter bit FILL_BIT = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  seq_pattern_gen_if.slave bus
);

  localparam int BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GCNT_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);
  localparam logic [GCNT_W-1:0] LAST_GAP = GCNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  // With a one-bit pattern every presented bit is also the last one.
  localparam bit SINGLE_BIT = (WIDTH == 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        state;
  logic [WIDTH-1:0]  pat;       // captured pattern, reloaded for each repetition
  logic [WIDTH-1:0]  sh;        // shift register, MSB is the bit now on d_out
  logic [WIDTH-1:0]  sh_adv;    // shift register after one advance
  logic [BCNT_W-1:0] bit_cnt;   // index of the bit now on d_out
  logic [REP_W-1:0]  rep_left;  // repetitions remaining, including the current one
  logic [GCNT_W-1:0] gap_cnt;   // index of the gap bit now on d_out

  logic d_out_r;
  logic d_valid_r;
  logic eop_r;
  logic busy_r;
  logic done_r;

  assign sh_adv      = sh << 1;
  assign bus.d_out   = d_out_r;
  assign bus.d_valid = d_valid_r;
  assign bus.eop     = eop_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

  // Transmission FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pat       <= '0;
      sh        <= '0;
      bit_cnt   <= '0;
      rep_left  <= '0;
      gap_cnt   <= '0;
      d_out_r   <= 1'b0;
      d_valid_r <= 1'b0;
      eop_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (bus.abort) begin
      // Abort wins over hold and start; the run is dropped without DONE.
      state     <= S_IDLE;
      d_out_r   <= 1'b0;
      d_valid_r <= 1'b0;
      eop_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.rep_num != '0) begin
              state     <= S_SHIFT;
              pat       <= bus.pattern;
              sh        <= bus.pattern;
              rep_left  <= bus.rep_num;
              bit_cnt   <= '0;
              d_out_r   <= bus.pattern[WIDTH-1];
              d_valid_r <= 1'b1;
              eop_r     <= SINGLE_BIT;
              busy_r    <= 1'b1;
            end else begin
              // Nothing to send: report completion straight away.
              state  <= S_FIN;
              done_r <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (bus.hold) begin
            // Freeze everything; only the qualifiers drop.
            d_valid_r <= 1'b0;
            eop_r     <= 1'b0;
          end else if (bit_cnt != LAST_BIT) begin
            sh        <= sh_adv;
            bit_cnt   <= bit_cnt + BCNT_W'(1);
            d_out_r   <= sh_adv[WIDTH-1];
            d_valid_r <= 1'b1;
            eop_r     <= ((bit_cnt + BCNT_W'(1)) == LAST_BIT);
          end else if (rep_left > REP_W'(1)) begin
            rep_left <= rep_left - REP_W'(1);
            if (GAP_LEN > 0) begin
              state     <= S_GAP;
              gap_cnt   <= '0;
              d_out_r   <= FILL_BIT;
              d_valid_r <= 1'b1;
              eop_r     <= 1'b0;
            end else begin
              // Back-to-back: next repetition's MSB follows the LSB directly.
              sh        <= pat;
              bit_cnt   <= '0;
              d_out_r   <= pat[WIDTH-1];
              d_valid_r <= 1'b1;
              eop_r     <= SINGLE_BIT;
            end
          end else begin
            state     <= S_FIN;
            d_out_r   <= 1'b0;
            d_valid_r <= 1'b0;
            eop_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end
        end

        S_GAP: begin
          if (bus.hold) begin
            d_valid_r <= 1'b0;
            eop_r     <= 1'b0;
          end else if (gap_cnt == LAST_GAP) begin
            state     <= S_SHIFT;
            sh        <= pat;
            bit_cnt   <= '0;
            d_out_r   <= pat[WIDTH-1];
            d_valid_r <= 1'b1;
            eop_r     <= SINGLE_BIT;
          end else begin
            gap_cnt   <= gap_cnt + GCNT_W'(1);
            d_out_r   <= FILL_BIT;
            d_valid_r <= 1'b1;
            eop_r     <= 1'b0;
          end
        end

        default: begin
          // FIN: DONE has been shown for one cycle; start here is ignored.
          state  <= S_IDLE;
          done_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (GAP_LEN=2 and GAP_LEN=0) share
// the same stimulus and are each compared every cycle against a stream-level
// reference model.
module tb_seq_pattern_gen;
  localparam int WIDTH = 8;
  localparam int REP_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             s_start;
  logic [WIDTH-1:0] s_pat;
  logic [REP_W-1:0] s_rep;
  logic             s_hold;
  logic             s_abort;

  seq_pattern_gen_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus_g ();
  seq_pattern_gen_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus_b ();

  assign bus_g.start   = s_start;
  assign bus_g.pattern = s_pat;
  assign bus_g.rep_num = s_rep;
  assign bus_g.hold    = s_hold;
  assign bus_g.abort   = s_abort;
  assign bus_b.start   = s_start;
  assign bus_b.pattern = s_pat;
  assign bus_b.rep_num = s_rep;
  assign bus_b.hold    = s_hold;
  assign bus_b.abort   = s_abort;

  seq_pattern_gen #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP_LEN(2), .FILL_BIT(1'b0)) dut_g (
    .clk(clk), .rst_n(rst_n), .bus(bus_g));
  seq_pattern_gen #(.WIDTH(WIDTH), .REP_W(REP_W), .GAP_LEN(0), .FILL_BIT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  // Reference model: the whole run is expanded into a list of stream bits,
  // then each clock edge either presents the next list entry, stalls, or ends.
  bit         sbit [2][256];
  bit         seop [2][256];
  int         slen [2];
  int         ph   [2];   // 0 idle, 1 sending, 2 done cycle
  int         idx  [2];
  logic [4:0] expv [2];   // {d_out, d_valid, eop, busy, done}

  function automatic int gap_of(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic void build(int k, logic [WIDTH-1:0] p, int reps);
    slen[k] = 0;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < WIDTH; i++) begin
        sbit[k][slen[k]] = p[WIDTH-1-i];
        seop[k][slen[k]] = (i == WIDTH - 1);
        slen[k]++;
      end
      if (r < reps - 1)
        for (int g = 0; g < gap_of(k); g++) begin
          sbit[k][slen[k]] = 1'b0;
          seop[k][slen[k]] = 1'b0;
          slen[k]++;
        end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; idx[k] = 0; expv[k] = 5'b0;
    end
  endfunction

  function automatic void model_edge(int k, bit st, bit hd, bit ab, logic [WIDTH-1:0] p, int reps);
    case (ph[k])
      0: begin
        if (st && !ab) begin
          if (reps > 0) begin
            build(k, p, reps);
            ph[k] = 1; idx[k] = 0;
            expv[k] = {sbit[k][0], 1'b1, seop[k][0], 1'b1, 1'b0};
          end else begin
            ph[k] = 2; expv[k] = 5'b00001;
          end
        end else expv[k] = 5'b0;
      end
      1: begin
        if (ab) begin
          ph[k] = 0; expv[k] = 5'b0;
        end else if (hd) begin
          expv[k] = {expv[k][4], 1'b0, 1'b0, 1'b1, 1'b0};
        end else begin
          idx[k]++;
          if (idx[k] == slen[k]) begin
            ph[k] = 2; expv[k] = 5'b00001;
          end else
            expv[k] = {sbit[k][idx[k]], 1'b1, seop[k][idx[k]], 1'b1, 1'b0};
        end
      end
      default: begin
        ph[k] = 0; expv[k] = 5'b0;
      end
    endcase
  endfunction

  function automatic logic [4:0] obs(int k);
    if (k == 0) return {bus_g.d_out, bus_g.d_valid, bus_g.eop, bus_g.busy, bus_g.done};
    return {bus_b.d_out, bus_b.d_valid, bus_b.eop, bus_b.busy, bus_b.done};
  endfunction

  // Called at a falling edge: apply inputs, advance the model over the next
  // rising edge, and return at the following falling edge.
  task automatic tick(bit st, bit hd, bit ab);
    s_start = st; s_hold = hd; s_abort = ab;
    for (int k = 0; k < 2; k++) model_edge(k, st, hd, ab, s_pat, int'(s_rep));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    s_start = 0; s_pat = '0; s_rep = '0; s_hold = 0; s_abort = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 5'b0) begin
        bad++; $display("FAIL reset[%0d] got=%b want=%b", k, obs(k), 5'b0);
      end
    end
    rst_n = 1;
    tick(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== expv[k]) begin
        bad++; $display("FAIL reset_idle[%0d] got=%b want=%b", k, obs(k), expv[k]);
      end
    end
  endtask

  task automatic test_single();
    int done_cyc;
    done_cyc = -1;
    s_pat = 8'hAB; s_rep = 4'd1;
    for (int c = 0; c < 11; c++) begin
      tick(c == 0, 0, 0);
      if (bus_g.done && done_cyc < 0) done_cyc = c;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv[k]) begin
          bad++; $display("FAIL single[%0d] cyc=%0d got=%b want=%b", k, c, obs(k), expv[k]);
        end
      end
    end
    total++;
    if (done_cyc !== 8) begin
      bad++; $display("FAIL single_done_cycle got=%0d want=%0d", done_cyc, 8);
    end
  endtask

  task automatic test_repeat_gap();
    int nval[2], neop[2];
    nval = '{0, 0}; neop = '{0, 0};
    s_pat = 8'hAB; s_rep = 4'd3;
    for (int c = 0; c < 32; c++) begin
      tick(c == 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        nval[k] += int'(obs(k)[3]);
        neop[k] += int'(obs(k)[2]);
        total++;
        if (obs(k) !== expv[k]) begin
          bad++; $display("FAIL repeat_gap[%0d] cyc=%0d got=%b want=%b", k, c, obs(k), expv[k]);
        end
      end
    end
    total++;
    if (nval[0] !== 28) begin
      bad++; $display("FAIL repeat_gap_valid_count got=%0d want=%0d", nval[0], 28);
    end
    total++;
    if (neop[0] !== 3) begin
      bad++; $display("FAIL repeat_gap_eop_count got=%0d want=%0d", neop[0], 3);
    end
  endtask

  task automatic test_back_to_back();
    int nval, first, last;
    nval = 0; first = -1; last = -1;
    s_pat = 8'hAB; s_rep = 4'd2;
    for (int c = 0; c < 22; c++) begin
      tick(c == 0, 0, 0);
      if (bus_b.d_valid) begin
        nval++; last = c;
        if (first < 0) first = c;
      end
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv[k]) begin
          bad++; $display("FAIL back_to_back[%0d] cyc=%0d got=%b want=%b", k, c, obs(k), expv[k]);
        end
      end
    end
    total++;
    if (nval !== 16 || (last - first) !== 15) begin
      bad++; $display("FAIL back_to_back_span got=%0d/%0d want=16/15", nval, last - first);
    end
  endtask

  task automatic test_rep_zero();
    bit saw_valid;
    int ndone;
    saw_valid = 0; ndone = 0;
    s_pat = 8'($urandom); s_rep = 4'd0;
    for (int c = 0; c < 4; c++) begin
      tick(c == 0, 0, 0);
      if (bus_g.d_valid || bus_b.d_valid) saw_valid = 1;
      ndone += int'(bus_g.done);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv[k]) begin
          bad++; $display("FAIL rep_zero[%0d] cyc=%0d got=%b want=%b", k, c, obs(k), expv[k]);
        end
      end
    end
    total++;
    if (saw_valid !== 1'b0 || ndone !== 1) begin
      bad++; $display("FAIL rep_zero_summary got=valid%0d/done%0d want=valid0/done1", saw_valid, ndone);
    end
  endtask

  task automatic test_hold();
    int done_cyc;
    done_cyc = -1;
    s_pat = 8'hAB; s_rep = 4'd1;
    for (int c = 0; c < 14; c++) begin
      tick(c == 0, (c >= 5 && c <= 7), 0);
      if (bus_g.done && done_cyc < 0) done_cyc = c;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv[k]) begin
          bad++; $display("FAIL hold[%0d] cyc=%0d got=%b want=%b", k, c, obs(k), expv[k]);
        end
      end
    end
    total++;
    if (done_cyc !== 11) begin
      bad++; $display("FAIL hold_done_cycle got=%0d want=%0d", done_cyc, 11);
    end
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    s_pat = 8'hAB; s_rep = 4'd2;
    for (int c = 0; c < 12; c++) begin
      tick(c == 0, 0, c == 4);
      ndone += int'(bus_g.done) + int'(bus_b.done);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv[k]) begin
          bad++; $display("FAIL abort[%0d] cyc=%0d got=%b want=%b", k, c, obs(k), expv[k]);
        end
      end
    end
    total++;
    if (ndone !== 0) begin
      bad++; $display("FAIL abort_no_done got=%0d want=%0d", ndone, 0);
    end
  endtask

  task automatic test_reset_mid_gap();
    s_pat = 8'hAB; s_rep = 4'd3;
    for (int c = 0; c < 9; c++) tick(c == 0, 0, 0);
    // Instance 0 is now presenting its first gap bit.
    total++;
    if (obs(0) !== expv[0] || expv[0] !== 5'b01010) begin
      bad++; $display("FAIL mid_gap_state got=%b want=%b", obs(0), 5'b01010);
    end
    #2 rst_n = 0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 5'b0) begin
        bad++; $display("FAIL async_reset[%0d] got=%b want=%b", k, obs(k), 5'b0);
      end
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick(0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv[k]) begin
          bad++; $display("FAIL after_reset[%0d] cyc=%0d got=%b want=%b", k, c, obs(k), expv[k]);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    int c;
    s_pat = 8'hAB; s_rep = 4'd2;
    tick(1, 0, 0);
    c = 0;
    while ((ph[0] != 0 || ph[1] != 0) && c < 100) begin
      // Scramble the inputs and keep poking START while the run is active.
      if (ph[0] == 1 && ph[1] == 1) begin
        s_pat = 8'($urandom); s_rep = 4'($urandom_range(1, 15));
        tick(1'($urandom_range(0, 1)), 0, 0);
      end else
        tick(0, 0, 0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== expv[k]) begin
          bad++; $display("FAIL start_busy[%0d] cyc=%0d got=%b want=%b", k, c, obs(k), expv[k]);
        end
      end
      c++;
    end
    total++;
    if (c >= 100) begin
      bad++; $display("FAIL start_busy_timeout got=%0d want<%0d", c, 100);
    end
  endtask

  task automatic test_random();
    int c;
    for (int t = 0; t < 40; t++) begin
      s_pat = 8'($urandom); s_rep = 4'($urandom_range(0, 15));
      tick(1, 1'($urandom_range(0, 1)), 0);
      c = 0;
      while ((ph[0] != 0 || ph[1] != 0) && c < 400) begin
        if (ph[0] == 1 && ph[1] == 1)
          tick(($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 150) == 0);
        else
          tick(0, ($urandom % 4) == 0, 0);
        for (int k = 0; k < 2; k++) begin
          total++;
          if (obs(k) !== expv[k]) begin
            bad++; $display("FAIL random[%0d] txn=%0d cyc=%0d got=%b want=%b", k, t, c, obs(k), expv[k]);
          end
        end
        c++;
      end
      total++;
      if (c >= 400) begin
        bad++; $display("FAIL random_timeout txn=%0d got=%0d want<%0d", t, c, 400);
      end
      tick(0, 0, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_repeat_gap();
    test_back_to_back();
    test_rep_zero();
    test_hold();
    test_abort();
    test_reset_mid_gap();
    test_start_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
